// File: rtl/string_art_line_scheduler.sv
// Greedy string-art line sequencer: scores every eligible pin from the current pin,
// commits the best positive-gain line to the solver and emits it, then repeats from that pin.
module string_art_line_scheduler #(
  parameter int NUM_PINS = 256,
  parameter int PIN_W    = 8,
  parameter int COORD_W  = 9,
  parameter int RED_W    = 19,
  parameter int LINE_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PIN_W-1:0]   start_pin,
  input  logic [LINE_W-1:0]  num_lines,
  input  logic [1:0]         mode,
  output logic               busy,
  output logic               done,
  output logic [LINE_W-1:0]  lines_drawn,
  output logic [PIN_W-1:0]   pin_addr,
  input  logic [COORD_W-1:0] pin_x,
  input  logic [COORD_W-1:0] pin_y,
  output logic               slv_req_val,
  input  logic               slv_req_rdy,
  output logic [COORD_W-1:0] slv_p1_x,
  output logic [COORD_W-1:0] slv_p1_y,
  output logic [COORD_W-1:0] slv_p2_x,
  output logic [COORD_W-1:0] slv_p2_y,
  output logic [1:0]         slv_mode,
  output logic               slv_change,
  input  logic               slv_resp_val,
  output logic               slv_resp_rdy,
  input  logic [RED_W-1:0]   slv_reduction,
  output logic               line_val,
  input  logic               line_rdy,
  output logic [PIN_W-1:0]   line_from,
  output logic [PIN_W-1:0]   line_to
);

  typedef enum logic [3:0] {
    S_IDLE, S_LD_CUR0, S_LD_CUR1, S_SKIP, S_FETCH0, S_FETCH1, S_ISSUE, S_WAIT_RESP,
    S_CFETCH0, S_CFETCH1, S_CISSUE, S_COMMIT_WAIT, S_EMIT, S_FIN
  } state_t;

  localparam logic [PIN_W-1:0] LAST_PIN = PIN_W'(NUM_PINS - 1);

  state_t state_q, state_d;

  logic [PIN_W-1:0]        cur_q, cur_d;
  logic [PIN_W-1:0]        prev_q, prev_d;
  logic                    prev_valid_q, prev_valid_d;
  logic [PIN_W-1:0]        cand_q, cand_d;
  logic [PIN_W-1:0]        best_q, best_d;
  logic signed [RED_W-1:0] best_red_q, best_red_d;
  logic                    best_valid_q, best_valid_d;
  logic [COORD_W-1:0]      p1_x_q, p1_x_d, p1_y_q, p1_y_d;
  logic [COORD_W-1:0]      p2_x_q, p2_x_d, p2_y_q, p2_y_d;
  logic [1:0]              mode_q, mode_d;
  logic [LINE_W-1:0]       num_lines_q, num_lines_d;
  logic [LINE_W-1:0]       lines_drawn_q, lines_drawn_d;

  logic              start_bad;
  logic              cand_skip;
  logic              cand_last;
  logic              better;
  logic              best_valid_nxt;
  logic [LINE_W-1:0] lines_inc;

  assign start_bad      = (num_lines == '0) || ({1'b0, start_pin} >= (PIN_W+1)'(NUM_PINS));
  assign cand_skip      = (cand_q == cur_q) || (prev_valid_q && (cand_q == prev_q));
  assign cand_last      = (cand_q == LAST_PIN);
  assign better         = $signed(slv_reduction) > best_red_q;
  assign best_valid_nxt = best_valid_q | better;
  assign lines_inc      = lines_drawn_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:        if (start) state_d = start_bad ? S_FIN : S_LD_CUR0;
      S_LD_CUR0:     state_d = S_LD_CUR1;
      S_LD_CUR1:     state_d = S_SKIP;
      S_SKIP: begin
        if (!cand_skip)     state_d = S_FETCH0;
        else if (cand_last) state_d = best_valid_q ? S_CFETCH0 : S_FIN;
      end
      S_FETCH0:      state_d = S_FETCH1;
      S_FETCH1:      state_d = S_ISSUE;
      S_ISSUE:       if (slv_req_rdy) state_d = S_WAIT_RESP;
      S_WAIT_RESP: begin
        // A skipped final candidate is handled in SKIP; here the last scored one closes the scan.
        if (slv_resp_val) begin
          if (cand_last) state_d = best_valid_nxt ? S_CFETCH0 : S_FIN;
          else           state_d = S_SKIP;
        end
      end
      S_CFETCH0:     state_d = S_CFETCH1;
      S_CFETCH1:     state_d = S_CISSUE;
      S_CISSUE:      if (slv_req_rdy) state_d = S_COMMIT_WAIT;
      S_COMMIT_WAIT: if (slv_resp_val) state_d = S_EMIT;
      S_EMIT:        if (line_rdy) state_d = (lines_inc == num_lines_q) ? S_FIN : S_LD_CUR0;
      S_FIN:         state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q != S_IDLE) && (state_q != S_FIN);
    done         = (state_q == S_FIN);
    slv_req_val  = (state_q == S_ISSUE) || (state_q == S_CISSUE);
    slv_change   = (state_q == S_CISSUE);
    slv_resp_rdy = (state_q == S_WAIT_RESP) || (state_q == S_COMMIT_WAIT);
    line_val     = (state_q == S_EMIT);
    pin_addr     = '0;
    case (state_q)
      S_LD_CUR0: pin_addr = cur_q;
      S_FETCH0:  pin_addr = cand_q;
      S_CFETCH0: pin_addr = best_q;
      default:   pin_addr = '0;
    endcase
    line_from   = cur_q;
    line_to     = best_q;
    slv_p1_x    = p1_x_q;
    slv_p1_y    = p1_y_q;
    slv_p2_x    = p2_x_q;
    slv_p2_y    = p2_y_q;
    slv_mode    = mode_q;
    lines_drawn = lines_drawn_q;
  end

  always_comb begin
    cur_d         = cur_q;
    prev_d        = prev_q;
    prev_valid_d  = prev_valid_q;
    cand_d        = cand_q;
    best_d        = best_q;
    best_red_d    = best_red_q;
    best_valid_d  = best_valid_q;
    p1_x_d        = p1_x_q;
    p1_y_d        = p1_y_q;
    p2_x_d        = p2_x_q;
    p2_y_d        = p2_y_q;
    mode_d        = mode_q;
    num_lines_d   = num_lines_q;
    lines_drawn_d = lines_drawn_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_d         = start_pin;
          mode_d        = mode;
          num_lines_d   = num_lines;
          lines_drawn_d = '0;
          prev_valid_d  = 1'b0;
        end
      end
      S_LD_CUR1: begin
        p1_x_d       = pin_x;
        p1_y_d       = pin_y;
        cand_d       = '0;
        best_d       = '0;
        best_red_d   = '0;
        best_valid_d = 1'b0;
      end
      S_SKIP: if (cand_skip && !cand_last) cand_d = cand_q + 1'b1;
      S_FETCH1, S_CFETCH1: begin
        p2_x_d = pin_x;
        p2_y_d = pin_y;
      end
      S_WAIT_RESP: begin
        // Strict compare: on a tie the earlier (lower) pin stays best.
        if (slv_resp_val) begin
          if (better) begin
            best_d       = cand_q;
            best_red_d   = $signed(slv_reduction);
            best_valid_d = 1'b1;
          end
          if (!cand_last) cand_d = cand_q + 1'b1;
        end
      end
      S_EMIT: begin
        if (line_rdy) begin
          lines_drawn_d = lines_inc;
          prev_d        = cur_q;
          prev_valid_d  = 1'b1;
          cur_d         = best_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_q         <= '0;
      prev_q        <= '0;
      prev_valid_q  <= 1'b0;
      cand_q        <= '0;
      best_q        <= '0;
      best_red_q    <= '0;
      best_valid_q  <= 1'b0;
      p1_x_q        <= '0;
      p1_y_q        <= '0;
      p2_x_q        <= '0;
      p2_y_q        <= '0;
      mode_q        <= '0;
      num_lines_q   <= '0;
      lines_drawn_q <= '0;
    end else begin
      cur_q         <= cur_d;
      prev_q        <= prev_d;
      prev_valid_q  <= prev_valid_d;
      cand_q        <= cand_d;
      best_q        <= best_d;
      best_red_q    <= best_red_d;
      best_valid_q  <= best_valid_d;
      p1_x_q        <= p1_x_d;
      p1_y_q        <= p1_y_d;
      p2_x_q        <= p2_x_d;
      p2_y_q        <= p2_y_d;
      mode_q        <= mode_d;
      num_lines_q   <= num_lines_d;
      lines_drawn_q <= lines_drawn_d;
    end
  end

endmodule

// File: tb/tb_string_art_line_scheduler.sv
// Scoreboard bench for the line scheduler: 8-pin ring, pin k at (10k,20k), table-driven solver model.
module tb_string_art_line_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  start_pin = '0;
  logic [15:0] num_lines = '0;
  logic [1:0]  mode = '0;
  logic        busy, done;
  logic [15:0] lines_drawn;
  logic [2:0]  pin_addr;
  logic [8:0]  pin_x = '0, pin_y = '0;
  logic        slv_req_val;
  logic        slv_req_rdy = 1'b0;
  logic [8:0]  slv_p1_x, slv_p1_y, slv_p2_x, slv_p2_y;
  logic [1:0]  slv_mode;
  logic        slv_change;
  logic        slv_resp_val = 1'b0;
  logic        slv_resp_rdy;
  logic [18:0] slv_reduction = '0;
  logic        line_val;
  logic        line_rdy = 1'b0;
  logic [2:0]  line_from, line_to;

  string_art_line_scheduler #(
    .NUM_PINS(8), .PIN_W(3), .COORD_W(9), .RED_W(19), .LINE_W(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .start_pin(start_pin), .num_lines(num_lines),
    .mode(mode), .busy(busy), .done(done), .lines_drawn(lines_drawn), .pin_addr(pin_addr),
    .pin_x(pin_x), .pin_y(pin_y), .slv_req_val(slv_req_val), .slv_req_rdy(slv_req_rdy),
    .slv_p1_x(slv_p1_x), .slv_p1_y(slv_p1_y), .slv_p2_x(slv_p2_x), .slv_p2_y(slv_p2_y),
    .slv_mode(slv_mode), .slv_change(slv_change), .slv_resp_val(slv_resp_val),
    .slv_resp_rdy(slv_resp_rdy), .slv_reduction(slv_reduction), .line_val(line_val),
    .line_rdy(line_rdy), .line_from(line_from), .line_to(line_to)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] p1;
    logic [2:0] p2;
    logic       ch;
    logic [1:0] md;
  } req_t;

  req_t        exp_req[$];
  logic [5:0]  exp_line[$];
  logic [15:0] exp_done[$];

  int n_checks = 0;
  int n_err = 0;

  int red_tab[8][8];
  int req_stall = 0, resp_delay = 0, line_stall = 0;
  bit stray = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Registered pin-coordinate ROM.
  always @(posedge clk) begin
    pin_x <= 9'(10 * int'(pin_addr));
    pin_y <= 9'(20 * int'(pin_addr));
  end

  // Solver and line-sink responders: all handshake inputs change on the falling edge.
  bit          outstanding = 1'b0, req_fire = 1'b0, resp_fire = 1'b0;
  int          resp_wait = 0, stall_left = 0, lstall_left = 0;
  logic [18:0] pend_red = '0;
  always @(negedge clk) begin
    if (reset) begin
      slv_req_rdy = 1'b0; slv_resp_val = 1'b0; slv_reduction = '0; line_rdy = 1'b0;
      outstanding = 1'b0; req_fire = 1'b0; resp_fire = 1'b0; resp_wait = 0;
      stall_left = req_stall; lstall_left = line_stall;
    end else begin
      if (resp_fire) outstanding = 1'b0;
      if (req_fire) begin outstanding = 1'b1; resp_wait = resp_delay; end
      if (stray) slv_resp_val = 1'b1;
      else if (!outstanding) slv_resp_val = 1'b0;
      else if (!slv_resp_val) begin
        if (resp_wait == 0) begin slv_resp_val = 1'b1; slv_reduction = pend_red; end
        else resp_wait--;
      end
      if (slv_req_val && !outstanding) begin
        if (stall_left > 0) begin slv_req_rdy = 1'b0; stall_left--; end
        else slv_req_rdy = 1'b1;
      end else begin
        slv_req_rdy = 1'b0; stall_left = req_stall;
      end
      req_fire  = slv_req_val && slv_req_rdy;
      resp_fire = slv_resp_val && slv_resp_rdy && !stray;
      if (req_fire)
        pend_red = slv_change ? 19'sd12345 : 19'(red_tab[int'(slv_p1_x) / 10][int'(slv_p2_x) / 10]);
      if (line_val) begin
        if (lstall_left > 0) begin line_rdy = 1'b0; lstall_left--; end
        else line_rdy = 1'b1;
      end else begin
        line_rdy = 1'b0; lstall_left = line_stall;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT completes a handshake or signals done.
  logic [40:0] req_snap, line_snap;
  bit          have_req_snap = 1'b0, have_line_snap = 1'b0;
  always @(negedge clk) begin
    logic [40:0] rv, ev;
    req_t        e;
    #1;
    rv = {slv_p1_x, slv_p1_y, slv_p2_x, slv_p2_y, slv_mode, slv_change, 2'b00};
    if (!reset) begin
      if (slv_req_val && slv_req_rdy) begin
        have_req_snap = 1'b0;
        if (exp_req.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL req_unexpected: got p1=%0d p2=%0d change=%0b expected no request",
                   slv_p1_x / 10, slv_p2_x / 10, slv_change);
        end else begin
          e  = exp_req.pop_front();
          ev = {9'(10 * int'(e.p1)), 9'(20 * int'(e.p1)), 9'(10 * int'(e.p2)),
                9'(20 * int'(e.p2)), e.md, e.ch, 2'b00};
          chk("solver_req", 64'(rv), 64'(ev));
        end
        $display("req  p1=%0d p2=%0d mode=%0d change=%0b", slv_p1_x / 10, slv_p2_x / 10,
                 slv_mode, slv_change);
      end else if (slv_req_val) begin
        if (have_req_snap) chk("req_stable", 64'(rv), 64'(req_snap));
        else begin req_snap = rv; have_req_snap = 1'b1; end
      end else have_req_snap = 1'b0;

      if (line_val && line_rdy) begin
        have_line_snap = 1'b0;
        if (exp_line.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL line_unexpected: got %0d->%0d expected no line", line_from, line_to);
        end else chk("line", 64'({line_from, line_to}), 64'(exp_line.pop_front()));
        $display("line %0d->%0d", line_from, line_to);
      end else if (line_val) begin
        chk("no_req_in_emit", 64'(slv_req_val), 64'd0);
        if (have_line_snap) chk("line_stable", 64'({line_from, line_to}), 64'(line_snap));
        else begin line_snap = 41'({line_from, line_to}); have_line_snap = 1'b1; end
      end else have_line_snap = 1'b0;

      if (done) begin
        chk("busy_at_done", 64'(busy), 64'd0);
        if (exp_done.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL done_unexpected: got lines=%0d expected no done", lines_drawn);
        end else chk("done_lines", 64'(lines_drawn), 64'(exp_done.pop_front()));
        $display("done lines_drawn=%0d", lines_drawn);
      end
    end
  end

  task automatic push_req(input int p1, input int p2, input bit ch, input logic [1:0] md);
    req_t r;
    r.p1 = p1[2:0]; r.p2 = p2[2:0]; r.ch = ch; r.md = md;
    exp_req.push_back(r);
  endtask

  // Expected scoring requests for one scan, followed by the commit of the winner.
  task automatic push_line(input int cur, input int prv, input bit pv, input int best,
                           input logic [1:0] md);
    for (int c = 0; c < 8; c++)
      if (c != cur && !(pv && c == prv)) push_req(cur, c, 1'b0, md);
    push_req(cur, best, 1'b1, md);
    exp_line.push_back({cur[2:0], best[2:0]});
  endtask

  task automatic fill_tab(input int v);
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++) red_tab[a][b] = v;
  endtask

  task automatic tab_linear;
    fill_tab(0);
    for (int c = 0; c < 8; c++) red_tab[0][c] = c * 10;
  endtask

  task automatic tab_ties;
    fill_tab(1);
    for (int c = 0; c < 8; c++) begin red_tab[0][c] = 10; red_tab[2][c] = 5; end
    red_tab[0][2] = 40; red_tab[0][5] = 40;
    red_tab[2][5] = 30;
    red_tab[5][2] = 100; red_tab[5][6] = 50;
  endtask

  task automatic run_job(input string name, input int sp, input int nl, input logic [1:0] md,
                         input bit exp_busy, input int exp_lines);
    bit got;
    @(negedge clk);
    start_pin = sp[2:0]; num_lines = 16'(nl); mode = md; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({name, "_busy"}, 64'(busy), 64'(exp_busy));
    got = done;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      got = done;
    end
    if (!got) begin
      n_checks++; n_err++;
      $display("FAIL %s_timeout: got no done expected done within 3000 cycles", name);
    end
    repeat (2) @(negedge clk);
    chk({name, "_lines_held"}, 64'(lines_drawn), 64'(exp_lines));
    chk({name, "_sb_empty"}, 64'(exp_req.size() + exp_line.size() + exp_done.size()), 64'd0);
    exp_req.delete(); exp_line.delete(); exp_done.delete();
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_ctl"}, 64'({busy, done, slv_req_val, slv_resp_rdy, line_val, slv_change}), 64'd0);
    chk({name, "_lines"}, 64'(lines_drawn), 64'd0);
    chk({name, "_addr"}, 64'(pin_addr), 64'd0);
  endtask

  initial begin
    bit seen;
    fill_tab(0);
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    chk_reset_outputs("idle");

    // num_lines=0 ends immediately
    exp_done.push_back(16'd0);
    run_job("t0", 0, 0, 2'd1, 1'b0, 0);

    // T1: rising gain picks pin 7
    tab_linear();
    push_line(0, 0, 1'b0, 7, 2'd2);
    exp_done.push_back(16'd1);
    run_job("t1", 0, 1, 2'd2, 1'b1, 1);

    // T2: no positive gain anywhere
    fill_tab(-5);
    for (int c = 0; c < 8; c++) if (c != 3) push_req(3, c, 1'b0, 2'd1);
    exp_done.push_back(16'd0);
    run_job("t2", 3, 2, 2'd1, 1'b1, 0);

    // T3: tie resolves low, previous pin excluded
    tab_ties();
    push_line(0, 0, 1'b0, 2, 2'd3);
    push_line(2, 0, 1'b1, 5, 2'd3);
    push_line(5, 2, 1'b1, 6, 2'd3);
    exp_done.push_back(16'd3);
    run_job("t3", 0, 3, 2'd3, 1'b1, 3);

    // T4: solver stalls on both channels
    tab_linear();
    req_stall = 5; resp_delay = 7;
    push_line(0, 0, 1'b0, 7, 2'd0);
    exp_done.push_back(16'd1);
    run_job("t4", 0, 1, 2'd0, 1'b1, 1);
    req_stall = 0; resp_delay = 0;

    // T5: line sink back-pressure
    tab_ties();
    line_stall = 10;
    push_line(0, 0, 1'b0, 2, 2'd1);
    push_line(2, 0, 1'b1, 5, 2'd1);
    exp_done.push_back(16'd2);
    run_job("t5", 0, 2, 2'd1, 1'b1, 2);
    line_stall = 0;

    // T6: reset during WAIT_RESP, stray response, then a clean job
    tab_linear();
    resp_delay = 3;
    push_req(0, 1, 1'b0, 2'd2);
    @(negedge clk);
    start_pin = 3'd0; num_lines = 16'd1; mode = 2'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = slv_resp_rdy;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = slv_resp_rdy;
    end
    chk("t6_reached_wait", 64'(seen), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_outputs("t6_abort");
    reset = 1'b0;
    resp_delay = 0;
    stray = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t6_stray_ignored", 64'({busy, slv_resp_rdy, line_val, slv_req_val}), 64'd0);
    end
    stray = 1'b0;
    @(negedge clk);
    chk("t6_sb_empty", 64'(exp_req.size()), 64'd0);
    push_line(0, 0, 1'b0, 7, 2'd2);
    exp_done.push_back(16'd1);
    run_job("t6", 0, 1, 2'd2, 1'b1, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
